// File: rtl/deconv_pkg.sv
// deconv_pkg: shared defaults and FSM state type for the bit-plane deconversion block.
`default_nettype none

package deconv_pkg;

  localparam int unsigned C_NUM_ELEM = 16;
  localparam int unsigned C_ELEM_W   = 8;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    STALL = 1'b1
  } deconv_state_e;

endpackage

`default_nettype wire

// File: rtl/deconv_if.sv
// deconv_if: plane input and vector output handshakes; plane_last/frame_err exist only
// when DECONV_FRAME_CHECK_EN is defined.
`default_nettype none

interface deconv_if
  import deconv_pkg::*;
#(
  parameter int NUM_ELEM = C_NUM_ELEM,
  parameter int ELEM_W   = C_ELEM_W
) ();

  logic [NUM_ELEM-1:0]        plane_in;
  logic                       plane_valid;
  logic                       plane_ready;
  logic [NUM_ELEM*ELEM_W-1:0] vec_out;
  logic                       vec_valid;
  logic                       vec_ready;
`ifdef DECONV_FRAME_CHECK_EN
  logic                       plane_last;
  logic                       frame_err;
`endif

  modport master (
    output plane_in, plane_valid, vec_ready,
`ifdef DECONV_FRAME_CHECK_EN
    output plane_last,
    input  frame_err,
`endif
    input  plane_ready, vec_out, vec_valid
  );

  modport slave (
    input  plane_in, plane_valid, vec_ready,
`ifdef DECONV_FRAME_CHECK_EN
    input  plane_last,
    output frame_err,
`endif
    output plane_ready, vec_out, vec_valid
  );

endinterface

`default_nettype wire

// File: rtl/deconv_out_reg.sv
// deconv_out_reg: single-entry output register with valid/ready hold.
`default_nettype none

module deconv_out_reg #(
  parameter int VEC_W = 128
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic [VEC_W-1:0] data_i,
  input  wire logic             ready_i,
  output logic                  free_o,
  output logic                  valid_o,
  output logic [VEC_W-1:0]      data_o
);

  logic             valid_q;
  logic [VEC_W-1:0] data_q;

  // Free when empty or being drained on this edge, so back-to-back loads need no bubble.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/deconversion.sv
// deconversion: gathers ELEM_W MSB-first bit-planes into one NUM_ELEM-element vector.
// Optional frame checking (plane_last/frame_err) under DECONV_FRAME_CHECK_EN.
`default_nettype none

module deconversion
  import deconv_pkg::*;
#(
  parameter int NUM_ELEM = C_NUM_ELEM,
  parameter int ELEM_W   = C_ELEM_W
) (
  input wire logic clk,
  input wire logic rst,
  deconv_if.slave  bus
);

  localparam int CNT_W = (ELEM_W > 1) ? $clog2(ELEM_W) : 1;
  localparam int VEC_W = NUM_ELEM * ELEM_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ELEM_W - 1);

  deconv_state_e    state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] coll_q;
  logic [VEC_W-1:0] coll_merged;
  logic             accept, last_plane, out_free, out_load;
  logic [VEC_W-1:0] out_data;

  assign bus.plane_ready = (state_q == FILL);
  assign accept          = bus.plane_valid && (state_q == FILL);
  assign last_plane      = (cnt_q == CNT_LAST);

  // Plane p lands on bit ELEM_W-1-p of every element.
  for (genvar i = 0; i < NUM_ELEM; i++) begin : g_elem
    for (genvar b = 0; b < ELEM_W; b++) begin : g_bit
      assign coll_merged[i*ELEM_W + b] = (cnt_q == CNT_W'(ELEM_W - 1 - b)) ?
                                         bus.plane_in[i] : coll_q[i*ELEM_W + b];
    end
  end

`ifdef DECONV_FRAME_CHECK_EN
  logic err_q;
  assign bus.frame_err = err_q;
  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = (last_plane || bus.plane_last) ? '0 : cnt_q + 1'b1;
  end
  // Loading is keyed on the counter, so an early plane_last drops the partial vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else if (accept && (bus.plane_last != last_plane)) err_q <= 1'b1;
  end
`else
  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = last_plane ? '0 : cnt_q + 1'b1;
  end
`endif

  assign out_load = (accept && last_plane && out_free) || ((state_q == STALL) && out_free);
  assign out_data = (state_q == STALL) ? coll_q : coll_merged;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      coll_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) coll_q <= coll_merged;
      case (state_q)
        FILL:    if (accept && last_plane && !out_free) state_q <= STALL;
        STALL:   if (out_free) state_q <= FILL;
        default: state_q <= FILL;
      endcase
    end
  end

  deconv_out_reg #(
    .VEC_W (VEC_W)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (out_load),
    .data_i  (out_data),
    .ready_i (bus.vec_ready),
    .free_o  (out_free),
    .valid_o (bus.vec_valid),
    .data_o  (bus.vec_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_deconversion.sv
// tb_deconversion: directed scoreboard bench for deconversion.
`default_nettype none

module tb_deconversion;
  import deconv_pkg::*;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int VW = N * W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  deconv_if #(.NUM_ELEM(N), .ELEM_W(W)) bus ();

  deconversion #(.NUM_ELEM(N), .ELEM_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_pop = -1;
  bit b2b_mode = 1'b0;
  logic [VW-1:0] exp_q[$];
  logic          hold_pend = 1'b0;
  logic [VW-1:0] hold_data;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each vector handshake and checks hold under stall.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", VW'(bus.vec_valid), VW'(1));
        chk("hold_data", bus.vec_out, hold_data);
      end
      hold_pend = 1'b0;
      if (bus.vec_valid && bus.vec_ready) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_vec: observed %h expected no vector", bus.vec_out);
        end
        if (exp_q.size() != 0) begin
          chk("vec_out", bus.vec_out, exp_q.pop_front());
          if (b2b_mode && last_pop >= 0) chk("b2b_gap", VW'(cyc - last_pop), VW'(W));
          last_pop = cyc;
        end
      end else if (bus.vec_valid) begin
        hold_pend = 1'b1;
        hold_data = bus.vec_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_plane(input logic [N-1:0] p, input bit last);
    bit ok = 1'b0;
    bus.plane_in    = p;
    bus.plane_valid = 1'b1;
`ifdef DECONV_FRAME_CHECK_EN
    bus.plane_last  = last;
`endif
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.plane_ready) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL plane_accept_timeout: observed plane_ready=0 expected 1 within 100 cycles");
    end
    tick();
    bus.plane_valid = 1'b0;
`ifdef DECONV_FRAME_CHECK_EN
    bus.plane_last  = 1'b0;
`endif
  endtask

  task automatic send_vec(input logic [VW-1:0] v, input bit push);
    if (push) exp_q.push_back(v);
    for (int p = 0; p < W; p++) begin
      logic [N-1:0] pl;
      for (int i = 0; i < N; i++) pl[i] = v[i*W + (W-1-p)];
      send_plane(pl, p == W-1);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    logic [VW-1:0] va, vb, vc, vd, ve, rt, v80;
    bus.plane_in    = '0;
    bus.plane_valid = 1'b0;
    bus.vec_ready   = 1'b0;
`ifdef DECONV_FRAME_CHECK_EN
    bus.plane_last  = 1'b0;
`endif
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_plane_ready", VW'(bus.plane_ready), VW'(1));
    chk("rst_vec_valid", VW'(bus.vec_valid), VW'(0));
    chk("rst_vec_out", bus.vec_out, '0);
    rst = 1'b1;
    tick();

    // Single vector: only plane 0 set -> every element 0x80.
    bus.vec_ready = 1'b1;
    v80 = {N{8'h80}};
    exp_q.push_back(v80);
    send_plane({N{1'b1}}, 1'b0);
    for (int p = 1; p < W-1; p++) send_plane('0, 1'b0);
    chk("latency_pre", VW'(bus.vec_valid), VW'(0));
    send_plane('0, 1'b1);
    chk("latency_valid", VW'(bus.vec_valid), VW'(1));
    chk("latency_data", bus.vec_out, v80);
    tick();
    chk("valid_drop", VW'(bus.vec_valid), VW'(0));

    // Round trip: element i = i*17.
    for (int i = 0; i < N; i++) rt[i*W +: W] = W'(i * 17);
    send_vec(rt, 1'b1);
    tick();

    // Backpressure.
    bus.vec_ready = 1'b0;
    va = rand_vec();
    vb = rand_vec();
    send_vec(va, 1'b1);
    chk("bp_first_valid", VW'(bus.vec_valid), VW'(1));
    chk("bp_first_data", bus.vec_out, va);
    send_vec(vb, 1'b1);
    chk("bp_stall_ready", VW'(bus.plane_ready), VW'(0));
    chk("bp_held_data", bus.vec_out, va);
    repeat (2) tick();
    chk("bp_stall_ready2", VW'(bus.plane_ready), VW'(0));
    bus.vec_ready = 1'b1;
    tick();
    chk("bp_second_valid", VW'(bus.vec_valid), VW'(1));
    chk("bp_second_data", bus.vec_out, vb);
    chk("bp_resume_ready", VW'(bus.plane_ready), VW'(1));
    tick();
    chk("bp_drain", VW'(bus.vec_valid), VW'(0));

    // Back-to-back vectors.
    last_pop = -1;
    b2b_mode = 1'b1;
    for (int k = 0; k < 4; k++) send_vec(rand_vec(), 1'b1);
    tick();
    b2b_mode = 1'b0;

    // Reset with an unconsumed output and a partial vector in flight.
    bus.vec_ready = 1'b0;
    vd = rand_vec();
    send_vec(vd, 1'b0);
    chk("pre_rst_valid", VW'(bus.vec_valid), VW'(1));
    for (int k = 0; k < 3; k++) send_plane(N'($urandom), 1'b0);
    rst = 1'b0;
    tick();
    chk("mid_rst_valid", VW'(bus.vec_valid), VW'(0));
    chk("mid_rst_data", bus.vec_out, '0);
    chk("mid_rst_ready", VW'(bus.plane_ready), VW'(1));
    rst = 1'b1;
    bus.vec_ready = 1'b1;
    tick();
    vc = rand_vec();
    send_vec(vc, 1'b1);
    tick();

`ifdef DECONV_FRAME_CHECK_EN
    chk("frame_err_clean", VW'(bus.frame_err), VW'(0));
    for (int p = 0; p < 6; p++) send_plane(N'($urandom), p == 5);
    tick();
    chk("frame_err_set", VW'(bus.frame_err), VW'(1));
    ve = rand_vec();
    send_vec(ve, 1'b1);
    tick();
    chk("frame_err_sticky", VW'(bus.frame_err), VW'(1));
`else
    ve = '0;
`endif

    repeat (3) tick();
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
